// File: rtl/filter_pkg.sv
// Types shared by the median filter reader, filter core and frame writer.
package filter_pkg;
  localparam int PIX_W_DEF = 8;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} wr_state_e;

  // Counter width for n entries, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/filtered_frame_writer_if.sv
// Row input and pixel output bundle of the frame writer; slave = writer side.
// Macro FRAME_CHECKSUM_EN adds the frame_sum status signal.
interface filtered_frame_writer_if #(
  parameter int SIZE  = 100,
  parameter int PIX_W = 8
);
  localparam int OUT_N = SIZE - 2;

  logic                   row_valid;
  logic [OUT_N*PIX_W-1:0] row_in;
  logic                   px_ready;
  logic                   px_valid;
  logic [PIX_W-1:0]       px_data;
  logic                   px_eol;
  logic                   frame_done;
  logic                   busy;
  logic                   overflow;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0]            frame_sum;

  modport master (output row_valid, row_in, px_ready,
                  input  px_valid, px_data, px_eol, frame_done, busy, overflow, frame_sum);
  modport slave  (input  row_valid, row_in, px_ready,
                  output px_valid, px_data, px_eol, frame_done, busy, overflow, frame_sum);
`else
  modport master (output row_valid, row_in, px_ready,
                  input  px_valid, px_data, px_eol, frame_done, busy, overflow);
  modport slave  (input  row_valid, row_in, px_ready,
                  output px_valid, px_data, px_eol, frame_done, busy, overflow);
`endif
endinterface

// File: rtl/frame_buf_2d.sv
// N x N pixel store: whole-row write port, asynchronous single-pixel read port.
module frame_buf_2d
  import filter_pkg::*;
#(
  parameter int N     = 98,
  parameter int PIX_W = 8,
  localparam int CW   = cnt_w(N)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [CW-1:0]      wr_row_i,
  input  logic [N*PIX_W-1:0] row_i,
  input  logic [CW-1:0]      rd_row_i,
  input  logic [CW-1:0]      rd_col_i,
  output logic [PIX_W-1:0]   rd_px_o
);
  logic [PIX_W-1:0] mem_q  [N][N];
  logic [PIX_W-1:0] row_px [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign row_px[gi] = row_i[gi*PIX_W +: PIX_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int c = 0; c < N; c++) begin
        mem_q[wr_row_i][c] <= row_px[c];
      end
    end
  end

  assign rd_px_o = mem_q[rd_row_i][rd_col_i];
endmodule

// File: rtl/filtered_frame_writer.sv
// Captures OUT_N filtered rows, then drains them in raster order over valid/ready.
// Macro FRAME_CHECKSUM_EN adds a 16-bit running sum of accepted pixels (frame_sum).
module filtered_frame_writer
  import filter_pkg::*;
#(
  parameter int SIZE  = 100,
  parameter int PIX_W = PIX_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  filtered_frame_writer_if.slave fw_if
);
  localparam int OUT_N = SIZE - 2;
  localparam int CW    = cnt_w(OUT_N);
  localparam logic [CW-1:0] LAST = CW'(OUT_N - 1);

  wr_state_e        state_q;
  logic [CW-1:0]    wr_row_q, rd_row_q, rd_col_q;
  logic             px_valid_q, frame_done_q, overflow_q;
  logic [PIX_W-1:0] px_data_q;

  logic             wr_en, hs, col_wrap, final_px;
  logic [CW-1:0]    wr_addr, nxt_col_d, nxt_row_d, rd_row_d, rd_col_d;
  logic [PIX_W-1:0] rd_px, start_px;

  assign wr_en     = fw_if.row_valid && (state_q != DRAIN);
  assign wr_addr   = (state_q == FILL) ? wr_row_q : '0;
  assign hs        = px_valid_q && fw_if.px_ready;
  assign col_wrap  = (rd_col_q == LAST);
  assign final_px  = col_wrap && (rd_row_q == LAST);
  assign nxt_col_d = col_wrap ? '0 : rd_col_q + 1'b1;
  assign nxt_row_d = col_wrap ? rd_row_q + 1'b1 : rd_row_q;
  // Read port looks one pixel ahead while draining, and at (0,0) otherwise.
  assign rd_row_d  = (state_q == DRAIN && !final_px) ? nxt_row_d : '0;
  assign rd_col_d  = (state_q == DRAIN && !final_px) ? nxt_col_d : '0;
  // A single-row frame is written on the same edge it must be shown.
  assign start_px  = (OUT_N == 1) ? fw_if.row_in[PIX_W-1:0] : rd_px;

  frame_buf_2d #(.N(OUT_N), .PIX_W(PIX_W)) u_buf (
    .clk      (clk),
    .we_i     (wr_en),
    .wr_row_i (wr_addr),
    .row_i    (fw_if.row_in),
    .rd_row_i (rd_row_d),
    .rd_col_i (rd_col_d),
    .rd_px_o  (rd_px)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_row_q     <= '0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      px_valid_q   <= 1'b0;
      px_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (fw_if.row_valid) begin
            if (OUT_N == 1) begin
              state_q    <= DRAIN;
              px_valid_q <= 1'b1;
              px_data_q  <= start_px;
            end else begin
              state_q  <= FILL;
              wr_row_q <= CW'(1);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        FILL: begin
          if (fw_if.row_valid) begin
            if (wr_row_q == LAST) begin
              state_q    <= DRAIN;
              wr_row_q   <= '0;
              px_valid_q <= 1'b1;
              px_data_q  <= start_px;
            end else begin
              wr_row_q <= wr_row_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fw_if.row_valid) overflow_q <= 1'b1;
          if (hs) begin
            if (final_px) begin
              state_q      <= DONE;
              px_valid_q   <= 1'b0;
              frame_done_q <= 1'b1;
              rd_row_q     <= '0;
              rd_col_q     <= '0;
            end else begin
              rd_col_q  <= nxt_col_d;
              rd_row_q  <= nxt_row_d;
              px_data_q <= rd_px;
            end
          end
        end
      endcase
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] sum_q;

  // The first pixel of a frame restarts the sum, so it holds through DONE/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (hs) begin
      if (rd_row_q == '0 && rd_col_q == '0) sum_q <= 16'(px_data_q);
      else                                  sum_q <= sum_q + 16'(px_data_q);
    end
  end

  assign fw_if.frame_sum = sum_q;
`endif

  assign fw_if.px_valid   = px_valid_q;
  assign fw_if.px_data    = px_data_q;
  assign fw_if.px_eol     = px_valid_q && col_wrap;
  assign fw_if.frame_done = frame_done_q;
  assign fw_if.busy       = (state_q == FILL) || (state_q == DRAIN);
  assign fw_if.overflow   = overflow_q;
endmodule

// File: tb/tb_filtered_frame_writer.sv
// Directed/randomised frames against a raster-order reference model (SIZE=6).
// Checks frame_sum too when FRAME_CHECKSUM_EN is defined.
module tb_filtered_frame_writer;
  import filter_pkg::*;

  localparam int SIZE  = 6;
  localparam int PIX_W = 8;
  localparam int N     = SIZE - 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  filtered_frame_writer_if #(.SIZE(SIZE), .PIX_W(PIX_W)) fw_if ();
  filtered_frame_writer #(.SIZE(SIZE), .PIX_W(PIX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fw_if (fw_if)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] frame [N][N];
  logic       ovf_exp = 1'b0;
  logic       stopped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind 0: 16*row+col, 1: all 0x01, 2: random
  task automatic make_frame(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (kind)
          0:       frame[r][c] = 8'(16*r + c);
          1:       frame[r][c] = 8'h01;
          default: frame[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic feed(input int gap);
    logic [N*PIX_W-1:0] rowv;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) rowv[c*PIX_W +: PIX_W] = frame[r][c];
      fw_if.row_in    = rowv;
      fw_if.row_valid = 1'b1;
      @(negedge clk);
      fw_if.row_valid = 1'b0;
      if (r < N-1) begin
        chk("fill_busy", 32'(fw_if.busy), 32'd1);
        chk("fill_valid", 32'(fw_if.px_valid), 32'd0);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_busy", 32'(fw_if.busy), 32'd1);
          chk("gap_valid", 32'(fw_if.px_valid), 32'd0);
        end
      end
    end
  endtask

  // mode 0: always ready, 1: ready 1,0,0 pattern, 2: random ready
  task automatic drain(input int mode, input int ovf_at, input int stop_after, output logic stop_o);
    logic [7:0] exp_q[$];
    int         sum = 0;
    int         idx = 0;
    int         cyc = 0;
    logic       stalled = 1'b0;
    logic [7:0] held = '0;
    logic       rdy;
    stop_o = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exp_q.push_back(frame[r][c]);
        sum += int'(frame[r][c]);
      end
    sum = sum % 65536;
    while (idx < N*N && cyc < 300) begin
      if (stop_after > 0 && idx == stop_after) begin
        stop_o = 1'b1;
        break;
      end
      chk("drain_valid", 32'(fw_if.px_valid), 32'd1);
      chk("drain_busy", 32'(fw_if.busy), 32'd1);
      chk("overflow", 32'(fw_if.overflow), 32'(ovf_exp));
      if (stalled) chk("stall_hold", 32'(fw_if.px_data), 32'(held));
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      fw_if.px_ready = rdy;
      if (cyc == ovf_at) begin
        fw_if.row_in    = '1;
        fw_if.row_valid = 1'b1;
      end else begin
        fw_if.row_valid = 1'b0;
      end
      if (rdy) begin
        chk("px_data", 32'(fw_if.px_data), 32'(exp_q[idx]));
        chk("px_eol", 32'(fw_if.px_eol), 32'(idx % N == N-1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = fw_if.px_data;
      end
      @(negedge clk);
      if (cyc == ovf_at) ovf_exp = 1'b1;
      cyc++;
    end
    fw_if.px_ready  = 1'b0;
    fw_if.row_valid = 1'b0;
    if (stop_o) return;
    chk("drain_count", 32'(idx), 32'(N*N));
    chk("frame_done", 32'(fw_if.frame_done), 32'd1);
    chk("valid_drop", 32'(fw_if.px_valid), 32'd0);
    chk("ovf_end", 32'(fw_if.overflow), 32'(ovf_exp));
`ifdef FRAME_CHECKSUM_EN
    chk("frame_sum", 32'(fw_if.frame_sum), 32'(sum));
`endif
    @(negedge clk);
    chk("done_pulse", 32'(fw_if.frame_done), 32'd0);
    chk("idle_busy", 32'(fw_if.busy), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    fw_if.row_valid = 1'b0;
    fw_if.row_in    = '0;
    fw_if.px_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(fw_if.px_valid), 32'd0);
    chk("rst_data", 32'(fw_if.px_data), 32'd0);
    chk("rst_eol", 32'(fw_if.px_eol), 32'd0);
    chk("rst_done", 32'(fw_if.frame_done), 32'd0);
    chk("rst_busy", 32'(fw_if.busy), 32'd0);
    chk("rst_ovf", 32'(fw_if.overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame, then a back-to-back all-ones frame
    make_frame(0); feed(0); drain(0, -1, 0, stopped);
    make_frame(1); feed(0); drain(0, -1, 0, stopped);
    // backpressure
    make_frame(0); feed(0); drain(1, -1, 0, stopped);
    // gapped rows
    make_frame(0); feed(2); drain(0, -1, 0, stopped);
    // row arriving mid-drain is dropped, overflow is sticky
    make_frame(0); feed(0); drain(0, 3, 0, stopped);
    make_frame(2); feed(1); drain(2, -1, 0, stopped);

    // reset after five pixels
    make_frame(0); feed(0); drain(0, -1, 5, stopped);
    chk("stop_reached", 32'(stopped), 32'd1);
    rst_n = 1'b0;
    #1;
    ovf_exp = 1'b0;
    chk("mid_rst_valid", 32'(fw_if.px_valid), 32'd0);
    chk("mid_rst_busy", 32'(fw_if.busy), 32'd0);
    chk("mid_rst_ovf", 32'(fw_if.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    make_frame(0); feed(0); drain(0, -1, 0, stopped);

    // random frames, random gaps and random ready
    for (int k = 0; k < 3; k++) begin
      make_frame(2);
      feed(int'($urandom_range(0, 2)));
      drain(2, -1, 0, stopped);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
